reset_sequencer: RTL and testbench

RESET_SEQUENCER -- requirements
Module: reset_sequencer

---
 rtl/reset_sequencer.sv | 196 +++++++++++++++++++
 tb/tb_reset_sequencer.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reset_sequencer.sv
// reset_sequencer
//
// Purpose:
//   Staged reset generator. It holds every downstream reset domain in reset
//   until the PLL is locked and no reset request (debounced push button or
//   soft_reset) is active, then releases the domains one at a time, in order
//   0..CHANNELS-1, with STAGE_CYCLES clocks between releases. Losing lock
//   re-asserts all resets and the release sequence restarts after relock.
//   Falling edges of the synchronised lock signal are counted (saturating).
//
// Ports:
//   clk              in   system clock
//   reset            in   asynchronous active-high block reset
//   pll_locked       in   PLL lock indication, asynchronous to clk
//   button_n         in   push button, active-low, asynchronous
//   soft_reset       in   synchronous single-cycle reset request
//   rst_out          out  per-domain active-high resets (registered)
//   all_ready        out  high only while in RUN (registered)
//   state            out  HOLD=0, WAIT_LOCK=1, RELEASE=2, RUN=3
//   lock_loss_count  out  saturating count of synced lock falling edges

module reset_sequencer #(
    parameter int CHANNELS      = 4,
    parameter int SYNC_STAGES   = 2,
    parameter int DEBOUNCE_BITS = 16,
    parameter int STAGE_CYCLES  = 16,
    parameter int LOSS_WIDTH    = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  pll_locked,
    input  logic                  button_n,
    input  logic                  soft_reset,
    output logic [CHANNELS-1:0]   rst_out,
    output logic                  all_ready,
    output logic [1:0]            state,
    output logic [LOSS_WIDTH-1:0] lock_loss_count
);

    localparam logic [1:0] ST_HOLD      = 2'd0;
    localparam logic [1:0] ST_WAIT_LOCK = 2'd1;
    localparam logic [1:0] ST_RELEASE   = 2'd2;
    localparam logic [1:0] ST_RUN       = 2'd3;

    localparam int CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int ST_W = (STAGE_CYCLES > 1) ? $clog2(STAGE_CYCLES) : 1;

    localparam logic [CH_W-1:0] CH_LAST    = CH_W'(CHANNELS - 1);
    localparam logic [ST_W-1:0] STAGE_LAST = ST_W'(STAGE_CYCLES - 1);

    // Synchronizers: lock resets to "not locked", button to "released".
    logic [SYNC_STAGES-1:0]   r_lock_sync;
    logic [SYNC_STAGES-1:0]   r_btn_sync;
    logic                     w_locked_s;
    logic                     w_button_s;

    logic                     r_locked_d;
    logic                     w_lock_fall;

    logic [DEBOUNCE_BITS-1:0] r_db_cnt;
    logic                     r_pressed;

    logic [1:0]               r_state;
    logic [1:0]               w_state_next;
    logic [CHANNELS-1:0]      r_rst_out;
    logic [CHANNELS-1:0]      w_rst_next;
    logic [ST_W-1:0]          r_stage_cnt;
    logic [ST_W-1:0]          w_stage_next;
    logic [CH_W-1:0]          r_ch_idx;
    logic [CH_W-1:0]          w_ch_next;
    logic                     r_all_ready;
    logic [LOSS_WIDTH-1:0]    r_loss_cnt;

    assign w_locked_s  = r_lock_sync[SYNC_STAGES-1];
    assign w_button_s  = r_btn_sync[SYNC_STAGES-1];
    assign w_lock_fall = r_locked_d & ~w_locked_s;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_lock_sync <= '0;
            r_btn_sync  <= '1;
            r_locked_d  <= 1'b0;
        end else begin
            r_lock_sync <= {r_lock_sync[SYNC_STAGES-2:0], pll_locked};
            r_btn_sync  <= {r_btn_sync[SYNC_STAGES-2:0], button_n};
            r_locked_d  <= w_locked_s;
        end
    end

    // Debouncer: the counter saturates at all ones; the low sample that
    // finds it saturated is the 2^DEBOUNCE_BITS-th consecutive one.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_db_cnt  <= '0;
            r_pressed <= 1'b0;
        end else if (w_button_s) begin
            r_db_cnt  <= '0;
            r_pressed <= 1'b0;
        end else if (&r_db_cnt) begin
            r_pressed <= 1'b1;
        end else begin
            r_db_cnt  <= r_db_cnt + DEBOUNCE_BITS'(1);
        end
    end

    // Sequencer next-state logic. Reset requests override everything else.
    // Lock loss is tested on the level of locked_s: RELEASE/RUN are only
    // entered with locked_s high, so a low level there is always a fresh
    // falling edge, and no channel can be released while unlocked.
    always_comb begin
        w_state_next = r_state;
        w_rst_next   = r_rst_out;
        w_stage_next = r_stage_cnt;
        w_ch_next    = r_ch_idx;
        if (r_pressed || soft_reset) begin
            w_state_next = ST_HOLD;
            w_rst_next   = '1;
        end else begin
            case (r_state)
                ST_HOLD: begin
                    w_state_next = ST_WAIT_LOCK;
                    w_rst_next   = '1;
                end
                ST_WAIT_LOCK: begin
                    w_rst_next = '1;
                    if (w_locked_s) begin
                        w_state_next = ST_RELEASE;
                        w_stage_next = '0;
                        w_ch_next    = '0;
                    end
                end
                ST_RELEASE: begin
                    if (!w_locked_s) begin
                        w_state_next = ST_WAIT_LOCK;
                        w_rst_next   = '1;
                    end else if (r_stage_cnt == STAGE_LAST) begin
                        w_stage_next         = '0;
                        w_rst_next[r_ch_idx] = 1'b0;
                        if (r_ch_idx == CH_LAST) begin
                            w_state_next = ST_RUN;
                        end else begin
                            w_ch_next = r_ch_idx + CH_W'(1);
                        end
                    end else begin
                        w_stage_next = r_stage_cnt + ST_W'(1);
                    end
                end
                ST_RUN: begin
                    if (!w_locked_s) begin
                        w_state_next = ST_WAIT_LOCK;
                        w_rst_next   = '1;
                    end else begin
                        w_rst_next = '0;
                    end
                end
                default: begin
                    w_state_next = ST_HOLD;
                    w_rst_next   = '1;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= ST_HOLD;
            r_rst_out   <= '1;
            r_stage_cnt <= '0;
            r_ch_idx    <= '0;
            r_all_ready <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_rst_out   <= w_rst_next;
            r_stage_cnt <= w_stage_next;
            r_ch_idx    <= w_ch_next;
            // Decoded from the next state so all_ready lines up with state.
            r_all_ready <= (w_state_next == ST_RUN);
        end
    end

    // Lock-loss counter counts every synced falling edge, whatever the state
    // and even when a reset request is being honoured on the same edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_loss_cnt <= '0;
        end else if (w_lock_fall && !(&r_loss_cnt)) begin
            r_loss_cnt <= r_loss_cnt + LOSS_WIDTH'(1);
        end
    end

    assign rst_out         = r_rst_out;
    assign all_ready       = r_all_ready;
    assign state           = r_state;
    assign lock_loss_count = r_loss_cnt;

endmodule

// File: tb/tb_reset_sequencer.sv
// Self-checking bench for reset_sequencer (CHANNELS=4, STAGE_CYCLES=16,
// SYNC_STAGES=2, DEBOUNCE_BITS=4, LOSS_WIDTH=8). A behavioural model tracks
// the sequence as "cycles since RELEASE entry" and derives the expected
// reset vector from (k+1)*STAGE_CYCLES thresholds; directed scenarios are
// followed by a randomized run.

module tb_reset_sequencer;

    localparam int CH = 4;
    localparam int SS = 2;
    localparam int DB = 4;
    localparam int SC = 16;
    localparam int LW = 8;
    localparam int LOSS_MAX = (1 << LW) - 1;

    logic          clk        = 1'b0;
    logic          reset      = 1'b0;
    logic          pll_locked = 1'b0;
    logic          button_n   = 1'b1;
    logic          soft_reset = 1'b0;
    logic [CH-1:0] rst_out;
    logic          all_ready;
    logic [1:0]    state;
    logic [LW-1:0] lock_loss_count;

    reset_sequencer #(
        .CHANNELS      (CH),
        .SYNC_STAGES   (SS),
        .DEBOUNCE_BITS (DB),
        .STAGE_CYCLES  (SC),
        .LOSS_WIDTH    (LW)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .pll_locked      (pll_locked),
        .button_n        (button_n),
        .soft_reset      (soft_reset),
        .rst_out         (rst_out),
        .all_ready       (all_ready),
        .state           (state),
        .lock_loss_count (lock_loss_count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int m_state;        // 0 HOLD, 1 WAIT_LOCK, 2 RELEASE, 3 RUN
    int m_t;            // cycles elapsed since RELEASE entry
    int m_low_run;      // consecutive low synced button samples
    int m_loss;
    bit m_pressed;
    bit m_locked_prev;
    bit q_lock[$];      // delay lines modelling the synchronizer latency
    bit q_btn[$];

    function automatic void model_reset();
        m_state = 0; m_t = 0; m_low_run = 0; m_loss = 0;
        m_pressed = 0; m_locked_prev = 0;
        q_lock.delete(); q_btn.delete();
        for (int i = 0; i < SS; i++) begin
            q_lock.push_back(1'b0);
            q_btn.push_back(1'b1);
        end
    endfunction

    function automatic void model_edge();
        bit ls, bs, np;
        int ns, nt;
        if (reset) begin
            model_reset();
            return;
        end
        ls = q_lock[0];
        bs = q_btn[0];
        ns = m_state;
        nt = m_t;
        if (m_locked_prev && !ls && m_loss < LOSS_MAX) m_loss++;
        if (bs) begin
            m_low_run = 0;
            np = 0;
        end else begin
            if (m_low_run < (1 << DB)) m_low_run++;
            np = (m_low_run >= (1 << DB));
        end
        if (m_pressed || soft_reset) begin
            ns = 0;
        end else begin
            case (m_state)
                0: ns = 1;
                1: if (ls) begin ns = 2; nt = 0; end
                2: if (!ls) ns = 1;
                   else begin
                       nt = m_t + 1;
                       if (nt == CH * SC) ns = 3;
                   end
                default: if (!ls) ns = 1;
            endcase
        end
        m_state = ns;
        m_t = nt;
        m_pressed = np;
        m_locked_prev = ls;
        q_lock.push_back(pll_locked); void'(q_lock.pop_front());
        q_btn.push_back(button_n);    void'(q_btn.pop_front());
    endfunction

    function automatic logic [CH-1:0] exp_rst();
        logic [CH-1:0] r;
        r = '1;
        if (m_state == 3) r = '0;
        else if (m_state == 2)
            for (int k = 0; k < CH; k++) r[k] = (m_t < (k + 1) * SC);
        return r;
    endfunction

    // One clock: update the model at the edge, compare 2 time units later.
    task automatic step();
        @(posedge clk);
        model_edge();
        #2;
        check_val("state", state, m_state);
        check_val("rst_out", rst_out, exp_rst());
        check_val("all_ready", all_ready, (m_state == 3));
        check_val("lock_loss_count", lock_loss_count, m_loss);
        cyc++;
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    task automatic wait_state(input string tag, input logic [1:0] target, input int bound);
        int i;
        i = 0;
        while (state != target && i < bound) begin
            step();
            i++;
        end
        check_val(tag, (state == target), 1);
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        run(2);
        reset = 1'b0;
        cyc = 0;
    endtask

    logic [CH-1:0] stage_tbl [4];
    int entry, loss_before, btn_hold, n, cnt;

    initial begin
        stage_tbl = '{4'b1110, 4'b1100, 4'b1000, 4'b0000};
        model_reset();

        // Reset state without any clock edge.
        #1 reset = 1'b1;
        #1;
        check_val("rst_state", state, 0);
        check_val("rst_rst_out", rst_out, 4'hF);
        check_val("rst_all_ready", all_ready, 0);
        check_val("rst_loss", lock_loss_count, 0);
        run(3);
        reset = 1'b0;
        cyc = 0;
        $display("txn reset: state=%0d rst_out=%b", state, rst_out);

        // Lock at cycle 10, staged release.
        entry = -1;
        for (int i = 0; i < 100; i++) begin
            if (cyc == 10) pll_locked = 1'b1;
            step();
            if (entry < 0 && state == 2'd2) entry = cyc;
            for (int j = 1; j <= 4; j++)
                if (entry >= 0 && cyc == entry + j * SC)
                    check_val("stage_release", rst_out, stage_tbl[j-1]);
        end
        check_val("release_entry_12_13", (entry == 12 || entry == 13), 1);
        check_val("run_all_ready", all_ready, 1);
        check_val("run_state", state, 3);
        $display("txn lock_up: release entry cycle %0d, state=%0d", entry, state);

        // Lock loss mid-release, then relock.
        pll_locked = 1'b0;
        run(5);
        pll_locked = 1'b1;
        n = 0;
        while (rst_out != 4'b1100 && n < 200) begin step(); n++; end
        check_val("reach_1100", rst_out, 4'b1100);
        loss_before = m_loss;
        pll_locked = 1'b0;
        cnt = 0;
        while (rst_out != 4'hF && cnt < 10) begin step(); cnt++; end
        check_val("loss_within_3", (cnt <= 3), 1);
        run(1);
        check_val("loss_state_wait", state, 1);
        check_val("loss_count_inc", lock_loss_count, loss_before + 1);
        pll_locked = 1'b1;
        wait_state("relock_run", 2'd3, 200);
        $display("txn lock_loss: rst_out=1111 after %0d cycles, count=%0d", cnt, lock_loss_count);

        // Short button glitch has no effect; long press forces HOLD.
        button_n = 1'b0; run(10); button_n = 1'b1; run(10);
        check_val("short_press_run", state, 3);
        button_n = 1'b0;
        run(20);
        check_val("long_press_hold", state, 0);
        check_val("long_press_rst", rst_out, 4'hF);
        button_n = 1'b1;
        wait_state("press_wait_lock", 2'd1, 40);
        wait_state("press_rerun", 2'd3, 200);
        $display("txn button: long press held, sequence rerun state=%0d", state);

        // soft_reset on the same edge as a synced lock falling edge.
        loss_before = m_loss;
        pll_locked = 1'b0;
        run(2);
        soft_reset = 1'b1;
        run(1);
        soft_reset = 1'b0;
        check_val("soft_state", state, 0);
        check_val("soft_rst", rst_out, 4'hF);
        check_val("soft_loss", lock_loss_count, loss_before + 1);
        pll_locked = 1'b1;
        wait_state("soft_rerun", 2'd3, 200);
        $display("txn soft_reset: loss count %0d", lock_loss_count);

        // Asynchronous reset in the middle of RELEASE.
        pll_locked = 1'b0; run(4); pll_locked = 1'b1;
        wait_state("mid_release", 2'd2, 50);
        run(20);
        reset = 1'b1;
        #1;
        check_val("async_state", state, 0);
        check_val("async_rst", rst_out, 4'hF);
        check_val("async_ready", all_ready, 0);
        check_val("async_loss", lock_loss_count, 0);
        model_reset();
        run(2);
        reset = 1'b0;
        cyc = 0;
        wait_state("after_async_run", 2'd3, 200);
        $display("txn async_reset: immediate HOLD, then state=%0d", state);

        // 300 drop/relock cycles saturate the counter.
        pulse_reset();
        for (int i = 0; i < 300; i++) begin
            pll_locked = 1'b0; run(3);
            pll_locked = 1'b1; run(3);
        end
        check_val("loss_saturate", lock_loss_count, 255);
        $display("txn saturate: lock_loss_count=%0d", lock_loss_count);

        // Randomized traffic.
        pulse_reset();
        btn_hold = 0;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 149) == 0) pll_locked = ~pll_locked;
            if (btn_hold > 0) begin
                btn_hold--;
                button_n = 1'b0;
            end else begin
                button_n = 1'b1;
                if ($urandom_range(0, 399) == 0) btn_hold = $urandom_range(3, 40);
            end
            soft_reset = ($urandom_range(0, 499) == 0);
            reset = ($urandom_range(0, 1499) == 0);
            step();
        end
        reset = 1'b0;
        soft_reset = 1'b0;
        $display("txn random: 4000 cycles, final state=%0d loss=%0d", state, lock_loss_count);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
